// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Round-robin arbiter/sequencer that shares one FIFO counter/storage pair
//   between NREQ producers and one consumer. One operation (a push or a pop)
//   is granted per visit to IDLE. The FIFO therefore never sees push and pop
//   strobes in the same cycle, and its flags settle before the next decision.
//
//   Optional feature macro: FIFO_ARB_POP_PRIORITY_EN
//     defined   : a contested decision always goes to POP
//     undefined : a contested decision alternates, starting with PUSH after reset
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req/data_in  per-producer request and packed write word (lane i at i*DATA_WIDTH)
//   ack          one-hot, one-cycle pulse when producer i's word is pushed
//   pop_req      consumer request; pop_ack pulses when the pop is issued
//   flag_full    FIFO full flag, sampled only in IDLE
//   flag_empty   FIFO empty flag, sampled only in IDLE
//   enable_Push  push strobe to the FIFO
//   enable_Pop   pop strobe to the FIFO
//   push_data    registered write word; holds between pushes
//   grant_id     index of the last granted producer
//   busy         high while in PUSH or POP
module fifo_push_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] data_in,
  output logic [NREQ-1:0]            ack,
  input  logic                       pop_req,
  output logic                       pop_ack,
  input  logic                       flag_full,
  input  logic                       flag_empty,
  output logic                       enable_Push,
  output logic                       enable_Pop,
  output logic [DATA_WIDTH-1:0]      push_data,
  output logic [GW-1:0]              grant_id,
  output logic                       busy
);

  typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP} state_t;

  state_t                           state;
  logic [GW-1:0]                    rr_ptr;
  logic                             last_push;   // 1: last op was PUSH, 0: POP
  logic [NREQ-1:0][DATA_WIDTH-1:0]  lanes;
  logic [GW-1:0]                    win;
  logic                             push_ok, pop_ok, choose_push, choose_pop;

  assign lanes = data_in;

  // First requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int   j;
    logic found;
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = j[GW-1:0];
      end
    end
  end

  assign push_ok = (|req) & ~flag_full;
  assign pop_ok  = pop_req & ~flag_empty;

`ifdef FIFO_ARB_POP_PRIORITY_EN
  assign choose_push = push_ok & ~pop_ok;
`else
  // Contested: push only if the previous op was a pop.
  assign choose_push = push_ok & (~pop_ok | ~last_push);
`endif
  assign choose_pop  = pop_ok & ~choose_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      last_push   <= 1'b0;
      ack         <= '0;
      pop_ack     <= 1'b0;
      enable_Push <= 1'b0;
      enable_Pop  <= 1'b0;
      push_data   <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (choose_push) begin
            state       <= S_PUSH;
            grant_id    <= win;
            push_data   <= lanes[win];
            ack         <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            enable_Push <= 1'b1;
            busy        <= 1'b1;
          end else if (choose_pop) begin
            state      <= S_POP;
            enable_Pop <= 1'b1;
            pop_ack    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_PUSH: begin
          state       <= S_IDLE;
          rr_ptr      <= (grant_id == GW'(NREQ-1)) ? '0 : grant_id + 1'b1;
          last_push   <= 1'b1;
          ack         <= '0;
          enable_Push <= 1'b0;
          busy        <= 1'b0;
        end
        S_POP: begin
          state      <= S_IDLE;
          last_push  <= 1'b0;
          enable_Pop <= 1'b0;
          pop_ack    <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          ack         <= '0;
          pop_ack     <= 1'b0;
          enable_Push <= 1'b0;
          enable_Pop  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GW   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] data_in = '0;
  logic [NREQ-1:0]   ack;
  logic              pop_req = 1'b0;
  logic              pop_ack;
  logic              flag_full = 1'b0;
  logic              flag_empty = 1'b0;
  logic              enable_Push, enable_Pop, busy;
  logic [DW-1:0]     push_data;
  logic [GW-1:0]     grant_id;

  fifo_push_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .GW(GW)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
    .pop_req(pop_req), .pop_ack(pop_ack), .flag_full(flag_full),
    .flag_empty(flag_empty), .enable_Push(enable_Push), .enable_Pop(enable_Pop),
    .push_data(push_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_push;
    int       id;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level reference: one decision per IDLE visit, then one busy cycle.
  initial begin
    int  rr;
    bit  last_was_push;
    bit  busy_m;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        rr = 0; last_was_push = 0; busy_m = 0;
        exp_q.delete();
      end else if (busy_m) begin
        busy_m = 0;
      end else begin
        bit pu, po, take_push;
        pu = (req != 0) && !flag_full;
        po = pop_req && !flag_empty;
`ifdef FIFO_ARB_POP_PRIORITY_EN
        take_push = pu && !po;
`else
        take_push = pu && (!po || !last_was_push);
`endif
        if (take_push) begin
          exp_t e;
          int w;
          w = -1;
          for (int k = 0; k < NREQ; k++)
            if (w < 0 && req[(rr + k) % NREQ]) w = (rr + k) % NREQ;
          e.is_push = 1; e.id = w; e.d = data_in[w*DW +: DW];
          exp_q.push_back(e);
          rr = (w + 1) % NREQ; last_was_push = 1; busy_m = 1;
        end else if (po) begin
          exp_t e;
          e.is_push = 0; e.id = 0; e.d = '0;
          exp_q.push_back(e);
          last_was_push = 0; busy_m = 1;
        end
      end
    end
  end

  // Monitor: every strobe must match the head of the expected queue, with no slip.
  logic [DW-1:0] last_pd = '0;
  always @(negedge clk) begin
    if (!reset) begin
      last_pd = '0;
    end else begin
      bit strobe;
      strobe = enable_Push || enable_Pop || (ack != 0) || pop_ack;
      if (exp_q.size() == 0) begin
        if (strobe) chk("unexpected_op", {enable_Push, enable_Pop, pop_ack, ack}, 0);
        else begin
          chk("push_data_hold", push_data, last_pd);
          chk("busy_idle", busy, 0);
        end
      end else begin
        exp_t e;
        logic [NREQ-1:0] oh;
        e = exp_q.pop_front();
        oh = e.is_push ? (NREQ'(1) << e.id) : '0;
        chk("enable_Push", enable_Push, e.is_push);
        chk("enable_Pop", enable_Pop, !e.is_push);
        chk("pop_ack", pop_ack, !e.is_push);
        chk("ack", ack, oh);
        chk("busy_op", busy, 1);
        if (e.is_push) begin
          chk("push_data", push_data, e.d);
          chk("grant_id", grant_id, e.id);
          last_pd = e.d;
        end
      end
    end
  end

  logic [NREQ-1:0] keep = '0;
  bit keep_pop = 0;
  bit rnd_mode = 0;

  // Inputs change at negedge+1; producers drop on their ack and re-raise if told to.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) req[i] = 1'b0;
      if (!req[i] && (keep[i] || (rnd_mode && $urandom_range(0, 2) == 0))) begin
        req[i] = 1'b1;
        data_in[i*DW +: DW] = DW'($urandom);
      end
    end
    if (pop_ack) pop_req = 1'b0;
    if (!pop_req && (keep_pop || (rnd_mode && $urandom_range(0, 2) == 0))) pop_req = 1'b1;
    if (rnd_mode) begin
      flag_full  = ($urandom_range(0, 3) == 0);
      flag_empty = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("reset_outputs", {ack, pop_ack, enable_Push, enable_Pop, push_data, grant_id, busy}, 0);
    tick(); tick();
    reset = 1'b1;
  endtask

  initial begin
    bit got;
    // Reset state
    do_reset();
    tick();

    // Single push
    data_in[2*DW +: DW] = 8'hA5;
    req = 4'b0100;
    tick();
    chk("single_en", enable_Push, 1);
    chk("single_data", push_data, 8'hA5);
    chk("single_ack", ack, 4'b0100);
    chk("single_gid", grant_id, 2);
    tick();
    chk("single_after", {enable_Push, enable_Pop, ack, pop_ack}, 0);
    tick();

    // Round-robin with all producers held
    keep = 4'b1111;
    repeat (16) tick();
    keep = '0;
    repeat (10) tick();

    // Full blocks pushes, release grants within 2 cycles
    flag_full = 1'b1;
    req[0] = 1'b1; data_in[0 +: DW] = 8'h3C;
    repeat (10) begin
      tick();
      chk("full_block", {enable_Push, ack}, 0);
    end
    flag_full = 1'b0;
    got = 0;
    repeat (3) begin
      if (!got && ack == 4'b0001 && enable_Push) got = 1;
      if (!got) tick();
    end
    chk("full_release", got, 1);
    tick(); tick();

    // Empty blocks pops
    flag_empty = 1'b1;
    pop_req = 1'b1;
    repeat (5) begin
      tick();
      chk("empty_block", {enable_Pop, pop_ack}, 0);
    end
    flag_empty = 1'b0;
    tick(); tick();
    chk("empty_release_done", pop_req, 0);
    tick();

    // Contention right after reset
    req = '0; pop_req = 1'b0;
    do_reset();
    keep = 4'b0001; keep_pop = 1;
    repeat (14) tick();
    keep = '0; keep_pop = 0;
    repeat (10) tick();

    // Reset in the middle of a push
    req = 4'b0001; data_in[0 +: DW] = 8'h77;
    got = 0;
    repeat (6) if (!got) begin
      tick();
      got = enable_Push;
    end
    chk("mid_push_seen", got, 1);
    req = 4'b1010;
    data_in[1*DW +: DW] = 8'h11;
    data_in[3*DW +: DW] = 8'h33;
    do_reset();
    tick();
    chk("post_reset_gid", grant_id, 1);
    chk("post_reset_ack", ack, 4'b0010);
    chk("post_reset_data", push_data, 8'h11);
    repeat (8) tick();

    // Randomized traffic
    rnd_mode = 1;
    repeat (3000) tick();
    rnd_mode = 0;
    flag_full = 1'b0; flag_empty = 1'b0;
    repeat (30) tick();
    chk("drained", {req, pop_req}, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter and sequencer that shares one FIFO counter/storage pair between NREQ producers and one consumer. It watches the FIFO's `flag_full` and `flag_empty` and grants one operation at a time, either a push from one requester or a pop for the consumer. It then drives the FIFO's `enable_Push` and `enable_Pop` for exactly one cycle per operation and routes the granted requester's data onto the write bus. It sits between the producer blocks and the FIFO counter, so the counter never sees push and pop asserted in the same cycle.

## Interface
- NREQ, 4, number of producers (2..8)
- DATA_WIDTH, 8, width of each producer word
- GW, $clog2(NREQ) (minimum 1), width of grant_id
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  bit i high: producer i wants to write one word; held until its ack
- data_in  in  NREQ*DATA_WIDTH  packed; producer i at [i*DATA_WIDTH +: DATA_WIDTH]
- ack  out  NREQ  one-hot, one-cycle pulse: producer i's word was pushed this cycle
- pop_req  in  1  consumer wants one word; held until pop_ack
- pop_ack  out  1  one-cycle pulse: pop issued this cycle
- flag_full  in  1  from FIFO counter
- flag_empty  in  1  from FIFO counter
- enable_Push  out  1  push strobe to FIFO counter/storage
- enable_Pop  out  1  pop strobe to FIFO counter/storage
- push_data  out  DATA_WIDTH  registered write data, valid while enable_Push=1
- grant_id  out  GW  index of the last granted producer
- busy  out  1  high while in PUSH or POP state

## Operation
- FSM has three states: IDLE, PUSH, POP. All outputs are registered.
- Eligibility and arbitration are evaluated only in IDLE:
  - push_ok = |req & !flag_full
  - pop_ok = pop_req & !flag_empty
- Round-robin pick: search req from rr_ptr upward, modulo NREQ. The first set bit is the winner.
- IDLE transitions:
  - Both push_ok and pop_ok: the choice is made by policy (see Configuration).
  - Only push_ok: go to PUSH. Latch the winner into grant_id and its data_in lane into push_data.
  - Only pop_ok: go to POP.
  - Neither: stay in IDLE.
- PUSH, one cycle:
  - enable_Push=1, ack[grant_id]=1, busy=1.
  - rr_ptr <= grant_id+1, wrapping NREQ-1 -> 0.
  - last_op <= PUSH. Next state IDLE.
- POP, one cycle:
  - enable_Pop=1, pop_ack=1, busy=1.
  - last_op <= POP. Next state IDLE.
- enable_Push and enable_Pop are never high together. ack has at most one bit set.
- If req[i] drops after the grant, the push still completes with the latched data and ack[i] still pulses.
- Reset (async, any state):
  - State IDLE, rr_ptr=0, last_op=POP.
  - ack=0, pop_ack=0, enable_Push=0, enable_Pop=0, push_data=0, grant_id=0, busy=0.
  - An in-flight PUSH or POP is abandoned with no strobe.

## Timing
- Latency from req sampled in IDLE to enable_Push/ack is 1 cycle. Pop latency is the same.
- Maximum throughput is one operation per 2 cycles. This guarantees the FIFO flags have updated before the next IDLE evaluation.
- flag_full and flag_empty are sampled only in IDLE. Their value during PUSH or POP is ignored.
- push_data holds its value between pushes. It changes only on the IDLE->PUSH edge.

## Configuration
- FIFO_ARB_POP_PRIORITY_EN defined: when push_ok and pop_ok are both true, POP always wins. Producers can starve only while the consumer keeps requesting.
- Undefined (default): alternate. Choose PUSH if last_op==POP, otherwise POP. After reset, the first contested choice is PUSH.

## Test plan
- Single push: NREQ=4, req=4'b0100, lane2=8'hA5, flags 0.
  - Cycle after sampling: enable_Push=1, push_data=8'hA5, ack=4'b0100, grant_id=2.
  - Following cycle: all strobes 0.
- Round-robin: req=4'b1111 held, flag_full=0.
  - ack sequence is 0001, 0010, 0100, 1000, 0001, one pulse every 2 cycles.
- Full: flag_full=1, req=4'b0001 for 10 cycles -> no enable_Push, no ack.
  - Drop flag_full -> enable_Push and ack=0001 within 2 cycles.
- Empty: pop_req=1, flag_empty=1 -> enable_Pop=0, pop_ack=0.
  - Clear flag_empty -> pop_ack pulse 1 cycle after sampling.
- Contention: req=4'b0001 and pop_req held, both flags 0, right after reset.
  - Default build: PUSH, POP, PUSH, POP...
  - With FIFO_ARB_POP_PRIORITY_EN: POP on every grant until pop_req drops.
- Reset mid-PUSH: assert reset while enable_Push=1.
  - All outputs go to 0 immediately.
  - After release with req=4'b1010, the first grant is producer 1 (rr_ptr=0).
